// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mul_state_e;

    localparam int NDIGITS = 17;
    localparam int EXT_W   = 34;
    localparam int PP_W    = 36;

    // Two guard bits let MULHU operands with bit 31 set stay positive.
    function automatic logic [EXT_W-1:0] ext_operand(input logic [31:0] x, input logic is_signed);
        return {{2{is_signed & x[31]}}, x};
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product selector: maps one 3-bit digit and M to 0, +-M or +-2M.
module booth_r4_pp
    import mul_pkg::*;
(
    input  logic [2:0]              digit,
    input  logic [EXT_W-1:0]        m,
    output logic signed [PP_W-1:0]  pp
);

    logic signed [PP_W-1:0] m_s;

    always_comb begin
        m_s = signed'({{(PP_W-EXT_W){m[EXT_W-1]}}, m});
        pp  = '0;
        case (digit)
            3'b001, 3'b010: pp = m_s;
            3'b011:         pp = m_s <<< 1;
            3'b100:         pp = -(m_s <<< 1);
            3'b101, 3'b110: pp = -m_s;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_unit.sv
// Multi-cycle radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Handshake: start is sampled on a clock edge when the unit is not in RUN; busy is high for the
// 17 digit cycles; ready pulses for one cycle with result valid; kill aborts RUN without a ready.
module booth_mul_unit
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result,
    output mul_state_e      dbg_state
);

    localparam logic [4:0] LAST_CNT = 5'(NDIGITS - 1);

    mul_state_e             state, state_next;
    mul_op_e                op_q;
    logic [4:0]             cnt;
    logic [PP_W-1:0]        acc;
    logic [EXT_W-1:0]       q;
    logic                   q_m1;
    logic [EXT_W-1:0]       m;

    logic                   launch;
    logic                   sgn_a, sgn_b;
    logic signed [PP_W-1:0] pp;
    logic [PP_W-1:0]        sum;
    logic [PP_W-1:0]        acc_next;
    logic [EXT_W-1:0]       q_next;
    logic [63:0]            prod;
    logic [XLEN-1:0]        result_sel;

    booth_r4_pp u_pp (
        .digit (Wire_digit()),
        .m     (m),
        .pp    (pp)
    );

    function automatic logic [2:0] Wire_digit();
        return {q[1:0], q_m1};
    endfunction

    assign launch = start && !kill;
    assign sgn_a  = (mul_op_e'(op) == OP_MULH) || (mul_op_e'(op) == OP_MULHSU);
    assign sgn_b  = (mul_op_e'(op) == OP_MULH);

    // Add into the high part, then arithmetic-shift {acc, q} right by one Booth digit.
    always_comb begin
        sum        = acc + pp;
        acc_next   = {{2{sum[PP_W-1]}}, sum[PP_W-1:2]};
        q_next     = {sum[1:0], q[EXT_W-1:2]};
        prod       = {acc_next[29:0], q_next};
        result_sel = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (launch) state_next = S_RUN;
            S_RUN: begin
                if (kill)                 state_next = S_IDLE;
                else if (cnt == LAST_CNT) state_next = S_DONE;
            end
            S_DONE:  state_next = launch ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= OP_MUL;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            m      <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (launch && state != S_RUN) begin
                m    <= ext_operand(a, sgn_a);
                q    <= ext_operand(b, sgn_b);
                q_m1 <= 1'b0;
                acc  <= '0;
                cnt  <= '0;
                op_q <= mul_op_e'(op);
            end else if (state == S_RUN && !kill) begin
                acc  <= acc_next;
                q    <= q_next;
                q_m1 <= q[1];
                cnt  <= cnt + 5'd1;
                if (cnt == LAST_CNT) result <= result_sel;
            end
        end
    end

    assign busy      = (state == S_RUN);
    assign ready     = (state == S_DONE);
    assign dbg_state = state;

endmodule
